// File: rtl/lsu.sv
// Load/store unit: address generation, store lane/mask formatting and one-cycle load return.
// Build option LSU_RESERVED_GUARD_EN blocks writes into the reserved address region.
package lsu_pkg;

    localparam int unsigned LSU_PKG_ADDR_W = 32;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_LB   = 5'd10,
        OP_LH   = 5'd11,
        OP_LW   = 5'd12,
        OP_LBU  = 5'd13,
        OP_LHU  = 5'd14,
        OP_SB   = 5'd15,
        OP_SH   = 5'd16,
        OP_SW   = 5'd17
    } operator_e;

    typedef enum logic [1:0] {
        REG_PROGRAM  = 2'd0,
        REG_DMEM     = 2'd1,
        REG_PERIPH   = 2'd2,
        REG_RESERVED = 2'd3
    } region_e;

    typedef struct packed {
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        operator_e   instr;
        logic [4:0]  rd_addr;
        logic        fwd_en;
        logic        valid;
        logic [31:0] store_data;
    } agu_issue_s;

    // wb_* carry the stage-2 destination info registered alongside the load operator.
    typedef struct packed {
        logic [LSU_PKG_ADDR_W-1:0] p_addr;
        logic [31:0]               p_wdata;
        logic [31:0]               p_rdata;
        logic [3:0]                p_bytemask;
        logic                      p_wren;
        logic [4:0]                wb_rd_addr;
        logic                      wb_fwd_en;
        logic                      wb_valid;
    } o_lsu_s;

endpackage

module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned LSU_ADDR_W = 32  // 3..32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  agu_issue_s  i_funct_data,
    input  logic [31:0] i_p_rdata,
    output o_lsu_s      o_store_data
);

`ifdef LSU_RESERVED_GUARD_EN
    localparam logic RSV_GUARD = 1'b1;
`else
    localparam logic RSV_GUARD = 1'b0;
`endif

    logic [LSU_ADDR_W-1:0] addr_s;
    region_e               region_s;
    logic [3:0]            bytemask_s;
    logic [31:0]           wdata_s;
    logic                  is_store_s;
    logic                  wren_s;
    logic [31:0]           rdata_s;

    operator_e             op_d,    op_q;
    logic [4:0]            rd_d,    rd_q;
    logic                  fwd_d,   fwd_q;
    logic                  valid_d, valid_q;

    assign addr_s = i_funct_data.operand_a[LSU_ADDR_W-1:0]
                  + i_funct_data.operand_b[LSU_ADDR_W-1:0];

    // Region decode from the top address bits.
    always_comb begin
        region_s = REG_PROGRAM;
        if (!addr_s[LSU_ADDR_W-1]) begin
            region_s = REG_PROGRAM;
        end else if (!addr_s[LSU_ADDR_W-2]) begin
            region_s = REG_DMEM;
        end else if (!addr_s[LSU_ADDR_W-3]) begin
            region_s = REG_PERIPH;
        end else begin
            region_s = REG_RESERVED;
        end
    end

    // Byte mask and store lane formatting, driven by the operator only.
    always_comb begin
        bytemask_s = 4'b0000;
        wdata_s    = 32'h0000_0000;
        is_store_s = 1'b0;
        case (i_funct_data.instr)
            OP_LW, OP_SW:         bytemask_s = 4'b1111;
            OP_LH, OP_LHU, OP_SH: bytemask_s = 4'b0011;
            OP_LB, OP_LBU, OP_SB: bytemask_s = 4'b0001;
            default:              bytemask_s = 4'b0000;
        endcase
        case (i_funct_data.instr)
            OP_SW: begin
                wdata_s    = i_funct_data.store_data;
                is_store_s = 1'b1;
            end
            OP_SH: begin
                wdata_s    = {16'h0000, i_funct_data.store_data[15:0]};
                is_store_s = 1'b1;
            end
            OP_SB: begin
                wdata_s    = {24'h00_0000, i_funct_data.store_data[7:0]};
                is_store_s = 1'b1;
            end
            default: begin
                wdata_s    = 32'h0000_0000;
                is_store_s = 1'b0;
            end
        endcase
    end

    assign wren_s = i_funct_data.valid & is_store_s
                  & ~(RSV_GUARD & (region_s == REG_RESERVED));

    // Next-state for stage 2: invalid slots collapse to ADD so no load formatting occurs.
    always_comb begin
        op_d    = OP_ADD;
        rd_d    = i_funct_data.rd_addr;
        fwd_d   = i_funct_data.fwd_en;
        valid_d = i_funct_data.valid;
        if (i_funct_data.valid) begin
            op_d = i_funct_data.instr;
        end else begin
            op_d = OP_ADD;
        end
    end

    // Stage-2 registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q    <= OP_ADD;
            rd_q    <= 5'd0;
            fwd_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            rd_q    <= rd_d;
            fwd_q   <= fwd_d;
            valid_q <= valid_d;
        end
    end

    // Load data formatting from the low lanes of the returned word.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (op_q)
            OP_LB:   rdata_s = {{24{i_p_rdata[7]}}, i_p_rdata[7:0]};
            OP_LBU:  rdata_s = {24'h00_0000, i_p_rdata[7:0]};
            OP_LH:   rdata_s = {{16{i_p_rdata[15]}}, i_p_rdata[15:0]};
            OP_LHU:  rdata_s = {16'h0000, i_p_rdata[15:0]};
            OP_LW:   rdata_s = i_p_rdata;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Output bundle assembly.
    always_comb begin
        o_store_data            = '0;
        o_store_data.p_addr     = LSU_PKG_ADDR_W'(addr_s);
        o_store_data.p_wdata    = wdata_s;
        o_store_data.p_rdata    = rdata_s;
        o_store_data.p_bytemask = bytemask_s;
        o_store_data.p_wren     = wren_s;
        o_store_data.wb_rd_addr = rd_q;
        o_store_data.wb_fwd_en  = fwd_q;
        o_store_data.wb_valid   = valid_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one operation issued per cycle, checks at negedge+1.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    agu_issue_s  fd;
    logic [31:0] prdata;
    o_lsu_s      out;

    int n_tests = 0;
    int n_fail  = 0;

    lsu #(.LSU_ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_funct_data (fd),
        .i_p_rdata    (prdata),
        .o_store_data (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input operator_e op, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] sd,
                         input logic [4:0] rd, input logic fwd);
        fd.instr      = op;
        fd.valid      = v;
        fd.operand_a  = a;
        fd.operand_b  = b;
        fd.store_data = sd;
        fd.rd_addr    = rd;
        fd.fwd_en     = fwd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        prdata = 32'h0;
        issue(OP_ADD, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        prdata = 32'hFFFF_FFFF;
        #1;
        check("rst_rdata", out.p_rdata, 32'h0);
        check("rst_wb_valid", 32'(out.wb_valid), 32'h0);
        check("rst_wb_rd", 32'(out.wb_rd_addr), 32'h0);
        check("rst_wb_fwd", 32'(out.wb_fwd_en), 32'h0);

        // LB issue
        issue(OP_LB, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'hFFFF_FFFF, 5'd5, 1'b1);
        #1;
        check("lb_addr", out.p_addr, 32'h0000_0104);
        check("lb_mask", 32'(out.p_bytemask), 32'h1);
        check("lb_wren", 32'(out.p_wren), 32'h0);
        check("lb_wdata", out.p_wdata, 32'h0);
        step();

        prdata = 32'h1234_5680;
        issue(OP_LHU, 1'b1, 32'h0000_0200, 32'h0, 32'h0, 5'd6, 1'b0);
        #1;
        check("lb_rdata", out.p_rdata, 32'hFFFF_FF80);
        check("lb_wb_rd", 32'(out.wb_rd_addr), 32'd5);
        check("lb_wb_fwd", 32'(out.wb_fwd_en), 32'h1);
        check("lb_wb_valid", 32'(out.wb_valid), 32'h1);
        check("lhu_mask", 32'(out.p_bytemask), 32'h3);
        step();

        prdata = 32'hDEAD_8001;
        issue(OP_LH, 1'b1, 32'h0000_0200, 32'h0, 32'h0, 5'd7, 1'b0);
        #1;
        check("lhu_rdata", out.p_rdata, 32'h0000_8001);
        check("lhu_wb_rd", 32'(out.wb_rd_addr), 32'd6);
        check("lhu_wb_fwd", 32'(out.wb_fwd_en), 32'h0);
        step();

        prdata = 32'hDEAD_8001;
        issue(OP_LBU, 1'b1, 32'h0000_0300, 32'h0, 32'h0, 5'd8, 1'b0);
        #1;
        check("lh_rdata", out.p_rdata, 32'hFFFF_8001);
        step();

        prdata = 32'h1234_5680;
        issue(OP_LW, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 5'd9, 1'b0);
        #1;
        check("lbu_rdata", out.p_rdata, 32'h0000_0080);
        check("lw_inv_mask", 32'(out.p_bytemask), 32'hF);
        check("lw_inv_wren", 32'(out.p_wren), 32'h0);
        step();

        prdata = 32'hDEAD_BEEF;
        issue(OP_LW, 1'b1, 32'h0000_0400, 32'h0, 32'h0, 5'd10, 1'b0);
        #1;
        check("lw_inv_rdata", out.p_rdata, 32'h0);
        check("lw_inv_wb_valid", 32'(out.wb_valid), 32'h0);
        step();

        prdata = 32'hA5A5_5A5A;
        issue(OP_SW, 1'b1, 32'h8000_0000, 32'h0000_0010, 32'hCAFE_BABE, 5'd0, 1'b0);
        #1;
        check("lw_rdata", out.p_rdata, 32'hA5A5_5A5A);
        check("sw_addr", out.p_addr, 32'h8000_0010);
        check("sw_wren", 32'(out.p_wren), 32'h1);
        check("sw_mask", 32'(out.p_bytemask), 32'hF);
        check("sw_wdata", out.p_wdata, 32'hCAFE_BABE);
        step();

        prdata = 32'h1234_5678;
        issue(OP_SH, 1'b1, 32'h0000_2000, 32'h0, 32'h1234_5678, 5'd0, 1'b0);
        #1;
        check("sw_rdata", out.p_rdata, 32'h0);
        check("sh_wdata", out.p_wdata, 32'h0000_5678);
        check("sh_mask", 32'(out.p_bytemask), 32'h3);
        check("sh_wren", 32'(out.p_wren), 32'h1);
        step();

        issue(OP_SB, 1'b1, 32'h0000_2000, 32'h0, 32'h1234_5678, 5'd0, 1'b0);
        #1;
        check("sh_rdata", out.p_rdata, 32'h0);
        check("sb_wdata", out.p_wdata, 32'h0000_0078);
        check("sb_mask", 32'(out.p_bytemask), 32'h1);
        step();

        issue(OP_SW, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 5'd0, 1'b0);
        #1;
        check("sw_inv_wren", 32'(out.p_wren), 32'h0);
        step();

        issue(OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1234_5678, 5'd0, 1'b0);
        #1;
        check("wrap_addr", out.p_addr, 32'h0000_0001);
        check("add_mask", 32'(out.p_bytemask), 32'h0);
        check("add_wren", 32'(out.p_wren), 32'h0);
        check("add_wdata", out.p_wdata, 32'h0);
        step();

        prdata = 32'hFFFF_FFFF;
        issue(OP_SW, 1'b1, 32'hC000_0000, 32'h0000_0004, 32'h0, 5'd0, 1'b0);
        #1;
        check("add_rdata", out.p_rdata, 32'h0);
        check("periph_wren", 32'(out.p_wren), 32'h1);
        step();

        issue(OP_SH, 1'b1, 32'hE000_0000, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
`ifdef LSU_RESERVED_GUARD_EN
        check("rsv_wren", 32'(out.p_wren), 32'h0);
`else
        check("rsv_wren", 32'(out.p_wren), 32'h1);
`endif
        check("rsv_mask", 32'(out.p_bytemask), 32'h3);
        step();

        // LW followed by reset at the next edge
        issue(OP_LW, 1'b1, 32'h0000_0400, 32'h0, 32'h0, 5'd3, 1'b1);
        step();
        rst    = 1'b1;
        prdata = 32'h1122_3344;
        issue(OP_SW, 1'b1, 32'h0, 32'h0000_0008, 32'h0, 5'd0, 1'b0);
        #1;
        check("pre_rst_lw_rdata", out.p_rdata, 32'h1122_3344);
        check("in_rst_wren", 32'(out.p_wren), 32'h1);
        check("in_rst_addr", out.p_addr, 32'h0000_0008);
        step();
        rst    = 1'b0;
        prdata = 32'hFFFF_FFFF;
        issue(OP_ADD, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check("post_rst_rdata", out.p_rdata, 32'h0);
        check("post_rst_wb_valid", 32'(out.wb_valid), 32'h0);
        check("post_rst_wb_rd", 32'(out.wb_rd_addr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
